multicycle_mips_core: RTL and testbench



---
 rtl/mc_pkg.sv | 51 +++++
 rtl/multicycle_mips_core_if.sv | 11 +
 rtl/mc_controller.sv | 115 +++++++++++
 rtl/multicycle_mips_core.sv | 63 ++++++
 tb/tb_multicycle_mips_core.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, functs, ALU control codes, FSM states and control word for the multicycle MIPS core
package mc_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_IMM4 = 2'd2;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, ILLEGAL
  } state_t;
  typedef struct packed {
    logic       req;
    logic       we;
    logic       iord;
    logic       ir_we;
    logic       ab_we;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu_ctl;
    logic       aluout_we;
    logic       mdr_we;
    logic       rf_we;
    logic       rf_rd;
    logic       rf_mem;
    logic       pc_br;
    logic       pc_jmp;
    logic       retire;
  } ctrl_t;
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl);
    logic [31:0] s;
    s = ctl[2] ? a - b : a + b;
    return ctl[1:0] == 2'b00 ? a & b :
           ctl[1:0] == 2'b01 ? a | b :
           ctl[1:0] == 2'b10 ? s : {31'd0, $signed(a) < $signed(b)};
  endfunction
endpackage

// File: rtl/multicycle_mips_core_if.sv
// multicycle_mips_core_if: unified memory req/ready bus shared by fetch and data accesses
interface multicycle_mips_core_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle FSM and decode producing datapath enables; MULTICYCLE_BNE_EN adds bne
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic       eq,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      c,
  output logic       illegal
);
  state_t state, nxt;
  logic [2:0] fctl;
  logic fok, is_br, take;
  assign fctl = funct == F_ADD ? ALU_ADD : funct == F_SUB ? ALU_SUB :
                funct == F_AND ? ALU_AND : funct == F_OR ? ALU_OR : ALU_SLT;
  assign fok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
`ifdef MULTICYCLE_BNE_EN
  assign is_br = op == OP_BEQ || op == OP_BNE;
  assign take = (op == OP_BNE) ^ eq;
`else
  assign is_br = op == OP_BEQ;
  assign take = eq;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == ILLEGAL) illegal <= 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    c = '0;
    c.alu_ctl = ALU_ADD;
    case (state)
      FETCH: begin
        c.req = 1'b1;
        c.ir_we = ready;
        nxt = ready ? DECODE : FETCH;
      end
      DECODE: begin
        c.ab_we = 1'b1;
        c.srcb = SRCB_IMM4;
        c.aluout_we = 1'b1;
        nxt = op inside {OP_LW, OP_SW} ? MEMADR : op == OP_R ? EXEC : is_br ? BRANCH :
              op == OP_ADDI ? ADDIEX : op == OP_J ? JUMP : ILLEGAL;
      end
      MEMADR: begin
        c.srca = 1'b1;
        c.srcb = SRCB_IMM;
        c.aluout_we = 1'b1;
        nxt = op == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        c.req = 1'b1;
        c.iord = 1'b1;
        c.mdr_we = ready;
        nxt = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        c.rf_we = 1'b1;
        c.rf_mem = 1'b1;
        c.retire = 1'b1;
        nxt = FETCH;
      end
      MEMWR: begin
        c.req = 1'b1;
        c.we = 1'b1;
        c.iord = 1'b1;
        c.retire = ready;
        nxt = ready ? FETCH : MEMWR;
      end
      EXEC: begin
        c.srca = 1'b1;
        c.alu_ctl = fctl;
        c.aluout_we = fok;
        nxt = fok ? ALUWB : ILLEGAL;
      end
      ALUWB: begin
        c.rf_we = 1'b1;
        c.rf_rd = 1'b1;
        c.retire = 1'b1;
        nxt = FETCH;
      end
      ADDIEX: begin
        c.srca = 1'b1;
        c.srcb = SRCB_IMM;
        c.aluout_we = 1'b1;
        nxt = ADDIWB;
      end
      ADDIWB: begin
        c.rf_we = 1'b1;
        c.retire = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        c.pc_br = take;
        c.retire = 1'b1;
        nxt = FETCH;
      end
      JUMP: begin
        c.pc_jmp = 1'b1;
        c.retire = 1'b1;
        nxt = FETCH;
      end
      default: nxt = ILLEGAL;
    endcase
    c.req = c.req & ~reset;
  end
endmodule

// File: rtl/multicycle_mips_core.sv
// multicycle_mips_core: multicycle MIPS datapath on a single shared req/ready memory port
module multicycle_mips_core
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_mips_core_if.master mem,
  output logic [31:0]            pc,
  output logic [CNT_W-1:0]       instret,
  output logic                   illegal
);
  ctrl_t c;
  logic [31:0] ir, mdr, a, b, aluout, signimm, srca, srcb, alu_y, rs_v, rt_v, wd;
  logic [31:0] rf [32];
  logic [4:0] wa;
  mc_controller u_ctrl (
    .clk, .reset, .ready(mem.ready), .eq(a == b), .op(ir[31:26]), .funct(ir[5:0]), .c, .illegal
  );
  always_comb begin
    signimm = {{16{ir[15]}}, ir[15:0]};
    srca = c.srca ? a : pc;
    srcb = c.srcb == SRCB_B ? b : c.srcb == SRCB_IMM ? signimm : {signimm[29:0], 2'b00};
    alu_y = alu(srca, srcb, c.alu_ctl);
    rs_v = ir[25:21] == 5'd0 ? 32'd0 : rf[ir[25:21]];
    rt_v = ir[20:16] == 5'd0 ? 32'd0 : rf[ir[20:16]];
    wa = c.rf_rd ? ir[15:11] : ir[20:16];
    wd = c.rf_mem ? mdr : aluout;
  end
  assign mem.req = c.req;
  assign mem.we = c.we;
  assign mem.addr = ADDR_W'(c.iord ? aluout : pc);
  assign mem.wdata = b;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      ir <= '0;
      mdr <= '0;
      a <= '0;
      b <= '0;
      aluout <= '0;
      instret <= '0;
    end else begin
      if (c.ir_we) begin
        ir <= mem.rdata;
        pc <= pc + 32'd4;
      end
      if (c.ab_we) begin
        a <= rs_v;
        b <= rt_v;
      end
      if (c.aluout_we) aluout <= alu_y;
      if (c.mdr_we) mdr <= mem.rdata;
      if (c.pc_br) pc <= aluout;
      if (c.pc_jmp) pc <= {pc[31:28], ir[25:0], 2'b00};
      if (c.rf_we && wa != 5'd0) rf[wa] <= wd;
      if (c.retire) instret <= instret + 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_mips_core.sv
// tb_multicycle_mips_core: directed program phases against a req/ready memory model with wait states
module tb_multicycle_mips_core;
  import mc_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  multicycle_mips_core_if #(.ADDR_W(32)) bus ();
  multicycle_mips_core_if #(.ADDR_W(32)) bus2 ();
  logic [31:0] pc, pc2, instret, instret2;
  logic illegal, illegal2;
  multicycle_mips_core dut (.clk, .reset, .mem(bus), .pc, .instret, .illegal);
  multicycle_mips_core #(.RESET_PC(32'h1000_0000)) dut2 (
    .clk, .reset, .mem(bus2), .pc(pc2), .instret(instret2), .illegal(illegal2)
  );
  logic [31:0] mem [1024];
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int slow_lat = 0;
  int cnt = 0, addr8_cnt = 0, wr_cnt = 0, req_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0, mem12 = '0;
  int tests = 0, fails = 0;
  int base;
  always_comb begin
    bus.ready = bus.req && cnt >= ((bus.addr == slow_addr && !bus.we) ? slow_lat : 0);
    bus.rdata = mem[bus.addr[11:2]];
    bus2.ready = 1'b1;
    bus2.rdata = 32'h0800_0040;
  end
  always @(posedge clk) begin
    cnt <= (bus.req && !bus.ready) ? cnt + 1 : 0;
    if (bus.req && bus.addr == 32'd8) addr8_cnt <= addr8_cnt + 1;
    if (bus.req) req_cnt <= req_cnt + 1;
    if (bus.req && bus.we) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr <= bus.addr;
      wr_data <= bus.wdata;
    end
    if (bus.req && bus.we && bus.ready && bus.addr == 32'd12) mem12 <= bus.wdata;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  endtask
  initial begin
    clear_mem();
    mem[0] = 32'h2002_0005;
    mem[1] = 32'h8C03_0008;
    mem[2] = 32'hDEAD_BEEF;
    slow_addr = 32'd8;
    slow_lat = 3;
    tick(2);
    check("rst_pc", pc, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_req", {31'd0, bus.req}, 32'd0);
    check("rst_state", 32'(dut.u_ctrl.state), 32'(FETCH));
    reset = 1'b0;
    tick(4);
    check("addi_instret", instret, 32'd1);
    check("addi_rf2", dut.rf[2], 32'd5);
    check("addi_pc", pc, 32'd4);
    check("addi_next_addr", bus.addr, 32'd4);
    check("addi_next_req", {31'd0, bus.req}, 32'd1);
    base = addr8_cnt;
    tick(7);
    check("lw_instret_c7", instret, 32'd1);
    tick(1);
    check("lw_instret_c8", instret, 32'd2);
    check("lw_addr8_cycles", 32'(addr8_cnt - base), 32'd4);
    check("lw_rf3", dut.rf[3], 32'hDEAD_BEEF);
    check("lw_pc", pc, 32'd8);
    reset = 1'b1;
    clear_mem();
    mem[0] = 32'hAC02_000C;
    mem[1] = 32'h0800_0004;
    mem[4] = 32'h1000_FFFE;
    slow_addr = 32'hFFFF_FFFF;
    tick(1);
    reset = 1'b0;
    base = wr_cnt;
    tick(4);
    check("sw_write_cycles", 32'(wr_cnt - base), 32'd1);
    check("sw_addr", wr_addr, 32'd12);
    check("sw_wdata", wr_data, 32'd5);
    check("sw_mem12", mem12, 32'd5);
    check("sw_instret", instret, 32'd1);
    tick(3);
    check("j_pc", pc, 32'h10);
    tick(3);
    check("beq_taken_pc", pc, 32'd12);
    check("beq_instret", instret, 32'd3);
    reset = 1'b1;
    clear_mem();
    mem[0] = 32'h0800_0004;
    mem[4] = 32'h1040_FFFE;
    mem[5] = 32'hFC00_0000;
    tick(1);
    reset = 1'b0;
    tick(6);
    check("beq_not_taken_pc", pc, 32'd20);
    check("beq_nt_instret", instret, 32'd2);
    tick(2);
    check("illegal_set", {31'd0, illegal}, 32'd1);
    base = req_cnt;
    tick(5);
    check("illegal_no_req", 32'(req_cnt - base), 32'd0);
    check("illegal_instret", instret, 32'd2);
    check("illegal_sticky", {31'd0, illegal}, 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("illegal_clr", {31'd0, illegal}, 32'd0);
    check("illegal_rst_pc", pc, 32'd0);
    reset = 1'b1;
    clear_mem();
    mem[0] = 32'h0002_2022;
    mem[1] = 32'h0082_282A;
    mem[2] = 32'h0062_3824;
    mem[3] = 32'h0085_3025;
    mem[4] = 32'h0063_4020;
    mem[5] = 32'h2000_0007;
    mem[6] = 32'h0000_4820;
    mem[7] = 32'h0800_0007;
    tick(1);
    reset = 1'b0;
    tick(28);
    check("r_instret", instret, 32'd7);
    check("sub_rf4", dut.rf[4], 32'hFFFF_FFFB);
    check("slt_rf5", dut.rf[5], 32'd1);
    check("and_rf7", dut.rf[7], 32'd5);
    check("or_rf6", dut.rf[6], 32'hFFFF_FFFB);
    check("add_wrap_rf8", dut.rf[8], 32'hBD5B_7DDE);
    check("r0_reads_zero", dut.rf[9], 32'd0);
    reset = 1'b1;
    clear_mem();
    mem[0] = 32'h200A_0077;
    mem[1] = 32'h8C0A_0008;
    mem[2] = 32'hDEAD_BEEF;
    slow_addr = 32'd8;
    slow_lat = 20;
    tick(1);
    reset = 1'b0;
    tick(9);
    check("abort_pre_state", 32'(dut.u_ctrl.state), 32'(MEMRD));
    check("abort_pre_req", {31'd0, bus.req}, 32'd1);
    check("abort_pre_rf10", dut.rf[10], 32'h77);
    reset = 1'b1;
    #1;
    check("abort_req_in_reset", {31'd0, bus.req}, 32'd0);
    tick(1);
    check("abort_state", 32'(dut.u_ctrl.state), 32'(FETCH));
    check("abort_pc", pc, 32'd0);
    check("abort_rf10", dut.rf[10], 32'h77);
    tick(1);
    reset = 1'b0;
    tick(1);
    check("j_hi_pc_fetch", pc2, 32'h1000_0004);
    tick(2);
    check("j_hi_pc", pc2, 32'h1000_0100);
    check("j_hi_instret", instret2, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
